mux_sel_arbiter: RTL and testbench

- Two-channel round-robin arbiter that generates the select line for the downstream 2:1 mux (I0/I1/sel/out stage) in the signal_processing chain.
- Each channel requests the mux. The arbiter grants one channel at a time, holds the grant for a programmable dwell, then hands over fairly.
- It drives sel as a registered, glitch-free signal so the mux output only changes on clock edges.

---
 rtl/mux_sel_pkg.sv | 9 +
 rtl/mux_sel_arbiter_if.sv | 13 +
 rtl/mux_sel_arbiter_dwell_counter.sv | 26 ++
 rtl/mux_sel_arbiter.sv | 48 ++++
 tb/tb_mux_sel_arbiter.sv | 92 +++++++++
 5 files changed

// File: rtl/mux_sel_pkg.sv
// mux_sel_pkg: state encoding and select constants shared by the arbiter slice
package mux_sel_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_G0 = 2'd1;
  localparam logic [1:0] ST_G1 = 2'd2;
  localparam logic SEL_I0 = 1'b0;
  localparam logic SEL_I1 = 1'b1;
  typedef enum logic [1:0] {IDLE = ST_IDLE, G0 = ST_G0, G1 = ST_G1} state_t;
endpackage

// File: rtl/mux_sel_arbiter_if.sv
// mux_sel_arbiter_if: request/dwell inputs and registered mux-select outputs
interface mux_sel_arbiter_if #(parameter int DWELL_W = 4);
  logic req0;
  logic req1;
  logic [DWELL_W-1:0] dwell;
  logic sel;
  logic grant0;
  logic grant1;
  logic busy;
  logic switch;
  modport master (output req0, req1, dwell, input sel, grant0, grant1, busy, switch);
  modport slave (input req0, req1, dwell, output sel, grant0, grant1, busy, switch);
endinterface

// File: rtl/mux_sel_arbiter_dwell_counter.sv
// dwell_counter: latches the dwell on load and counts grant cycles up to it
module dwell_counter #(parameter int DWELL_W = 4) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               en,
  input  logic [DWELL_W-1:0] dwell,
  output logic               done
);
  logic [DWELL_W-1:0] cnt_q, cnt_d, dwell_q, dwell_d;
  always_comb begin
    cnt_d = load ? '0 : en ? cnt_q + 1'b1 : cnt_q;
    dwell_d = load ? dwell : dwell_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      dwell_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      dwell_q <= dwell_d;
    end
  end
  // compare before incrementing, so the maximum dwell never wraps the counter
  assign done = cnt_q == dwell_q;
endmodule

// File: rtl/mux_sel_arbiter.sv
// mux_sel_arbiter: two-channel round-robin arbiter producing a registered 2:1 mux select
module mux_sel_arbiter
  import mux_sel_pkg::*;
#(parameter int DWELL_W = 4) (
  input  logic                     clk,
  input  logic                     rst_n,
  mux_sel_arbiter_if.slave         bus
);
  state_t state_q, state_d, pick, swap;
  logic sel_q, sel_d, last_q, last_d, switch_q, switch_d;
  logic active, own, other, fin, start, done;
  always_comb begin
    active = state_q != IDLE;
    own = state_q == G1 ? bus.req1 : bus.req0;
    other = state_q == G1 ? bus.req0 : bus.req1;
    fin = active && (!own || done);
    pick = (bus.req0 && bus.req1) ? (last_q == SEL_I1 ? G0 : G1) :
           bus.req0 ? G0 : bus.req1 ? G1 : IDLE;
    swap = state_q == G0 ? G1 : G0;
    state_d = !active ? pick : !fin ? state_q : other ? swap : own ? state_q : IDLE;
    start = state_d != IDLE && (!active || fin);
    sel_d = start ? (state_d == G1 ? SEL_I1 : SEL_I0) : sel_q;
    last_d = start ? sel_d : last_q;
    switch_d = start;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q <= SEL_I0;
      last_q <= SEL_I1;
      switch_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q <= sel_d;
      last_q <= last_d;
      switch_q <= switch_d;
    end
  end
  dwell_counter #(.DWELL_W(DWELL_W)) u_cnt (
    .clk(clk), .rst_n(rst_n), .load(start), .en(active && !fin),
    .dwell(bus.dwell), .done(done)
  );
  assign bus.sel = sel_q;
  assign bus.grant0 = state_q == G0;
  assign bus.grant1 = state_q == G1;
  assign bus.busy = active;
  assign bus.switch = switch_q;
endmodule

// File: tb/tb_mux_sel_arbiter.sv
// tb_mux_sel_arbiter: directed vectors into a scoreboard checked by a negedge monitor
module tb_mux_sel_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i0 = 1'b0;
  logic i1 = 1'b1;
  logic mux_out;
  int total = 0;
  int bad = 0;
  typedef struct {
    string nm;
    logic [5:0] v;
  } exp_t;
  exp_t sb[$];
  mux_sel_arbiter_if #(.DWELL_W(4)) bus();
  mux_sel_arbiter #(.DWELL_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  assign mux_out = bus.sel ? i1 : i0;
  always #5 clk = ~clk;
  task automatic step(input logic rn, input logic r0, input logic r1, input logic [3:0] d,
                      input string nm, input logic es, input logic eg0, input logic eg1,
                      input logic esw);
    @(negedge clk);
    #1;
    rst_n = rn;
    bus.req0 = r0;
    bus.req1 = r1;
    bus.dwell = d;
    sb.push_back('{nm: nm, v: {es, eg0, eg1, eg0 | eg1, esw, es}});
  endtask
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      logic [5:0] act;
      e = sb.pop_front();
      act = {bus.sel, bus.grant0, bus.grant1, bus.busy, bus.switch, mux_out};
      total++;
      if (act !== e.v) begin
        bad++;
        $display("FAIL %s: got sel/g0/g1/busy/sw/out=%b expected %b", e.nm, act, e.v);
      end
    end
  end
  initial begin
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.dwell = '0;
    repeat (3) step(0, 1, 1, 2, "reset_hold", 0, 0, 0, 0);
    step(1, 1, 1, 2, "alt_c1", 0, 1, 0, 1);
    step(1, 1, 1, 2, "alt_c2", 0, 1, 0, 0);
    step(1, 1, 1, 2, "alt_c3", 0, 1, 0, 0);
    step(1, 1, 1, 2, "alt_c4", 1, 0, 1, 1);
    step(1, 1, 1, 2, "alt_c5", 1, 0, 1, 0);
    step(1, 1, 1, 2, "alt_c6", 1, 0, 1, 0);
    step(1, 1, 1, 2, "alt_c7", 0, 1, 0, 1);
    step(1, 1, 1, 2, "alt_c8", 0, 1, 0, 0);
    step(1, 1, 1, 2, "alt_c9", 0, 1, 0, 0);
    step(1, 1, 1, 0, "min_dwell_1", 1, 0, 1, 1);
    step(1, 1, 1, 0, "min_dwell_2", 0, 1, 0, 1);
    step(1, 1, 1, 0, "min_dwell_3", 1, 0, 1, 1);
    step(1, 1, 1, 0, "min_dwell_4", 0, 1, 0, 1);
    step(1, 0, 1, 7, "early_rel_g1", 1, 0, 1, 1);
    step(1, 0, 1, 7, "early_rel_g2", 1, 0, 1, 0);
    step(1, 0, 0, 7, "early_rel_idle", 1, 0, 0, 0);
    step(1, 0, 0, 7, "idle_sel_hold", 1, 0, 0, 0);
    for (int k = 0; k < 6; k++) step(1, 1, 0, 1, "regrant", 0, 1, 0, (k % 2) == 0);
    step(1, 0, 1, 3, "pre_rst_g1", 1, 0, 1, 1);
    step(1, 0, 1, 3, "pre_rst_cnt1", 1, 0, 1, 0);
    step(0, 0, 1, 3, "mid_grant_rst", 0, 0, 0, 0);
    step(1, 1, 1, 3, "post_rst_ch0", 0, 1, 0, 1);
    step(1, 1, 1, 3, "post_rst_hold", 0, 1, 0, 0);
    step(1, 0, 0, 3, "post_rst_idle", 0, 0, 0, 0);
    step(1, 0, 1, 15, "max_dwell_start", 1, 0, 1, 1);
    for (int k = 0; k < 15; k++) step(1, 0, 1, 0, "max_dwell_hold", 1, 0, 1, 0);
    step(1, 0, 1, 0, "max_dwell_regrant", 1, 0, 1, 1);
    step(1, 0, 1, 0, "new_dwell_regrant", 1, 0, 1, 1);
    @(negedge clk);
    @(negedge clk);
    #1;
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end
endmodule
